// File: rtl/oam_dma_ctrl_pkg.sv
// Shared definitions for the sprite DMA sequencer: register addresses,
// transfer length and the sequencer state encoding.
package oam_dma_ctrl_pkg;

    // CPU register that starts a sprite transfer.
    localparam logic [15:0] REG_OAMDMA  = 16'h4014;
    // PPU OAM data port; every put cycle targets this address.
    localparam logic [15:0] REG_OAMDATA = 16'h2004;
    // Bytes moved per transfer (one full OAM).
    localparam logic [8:0]  DMA_NUM_BYTES = 9'd256;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_HALT  = 3'd1,
        DMA_ALIGN = 3'd2,
        DMA_GET   = 3'd3,
        DMA_PUT   = 3'd4,
        DMA_DONE  = 3'd5
    } dma_state_e;

    // True when the CPU is writing the given register this cycle.
    function automatic logic is_reg_write(input logic [15:0] addr,
                                          input logic        rw,
                                          input logic [15:0] reg_addr);
        return (addr == reg_addr) && (rw == 1'b0);
    endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side bus bundle seen by the sprite DMA sequencer. The master modport
// is the sequencer itself; the slave modport is the CPU / bus-mux side.
interface oam_dma_ctrl_if;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data_o;
    logic [7:0]  bus_data_i;
    logic        cpu_rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_data_o;
    logic        dma_done;

    modport master (
        input  cpu_addr, cpu_rw, cpu_data_o, bus_data_i,
        output cpu_rdy, dma_active, dma_addr, dma_rw, dma_data_o, dma_done
    );

    modport slave (
        output cpu_addr, cpu_rw, cpu_data_o, bus_data_i,
        input  cpu_rdy, dma_active, dma_addr, dma_rw, dma_data_o, dma_done
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer. A CPU write to the DMA register latches a source
// page, stalls the CPU, then copies NUM_BYTES bytes from {page, 8'h00}
// upward into the OAM data port as alternating get/put cycles. Gets always
// fall on even parity slots, so an extra ALIGN cycle is inserted when the
// start lands on the wrong phase. All outputs are registered and derived
// from the next state, so they change cleanly on the clock edge.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = REG_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = REG_OAMDATA,
    parameter logic [8:0]  NUM_BYTES     = DMA_NUM_BYTES
) (
    input  logic            clk,
    input  logic            rst_n,
    oam_dma_ctrl_if.master  bus
);

    dma_state_e  state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        parity_q, parity_d;
    logic        cpu_rdy_q, cpu_rdy_d;
    logic        dma_active_q, dma_active_d;
    logic [15:0] dma_addr_q, dma_addr_d;
    logic        dma_rw_q, dma_rw_d;
    logic [7:0]  dma_data_q, dma_data_d;
    logic        dma_done_q, dma_done_d;
    logic        start_req;

    assign start_req = is_reg_write(bus.cpu_addr, bus.cpu_rw, DMA_REG_ADDR);

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        cnt_d      = cnt_q;
        dma_data_d = dma_data_q;
        // Free-running get/put phase marker.
        parity_d   = ~parity_q;

        case (state_q)
            DMA_IDLE: begin
                if (start_req) begin
                    page_d  = bus.cpu_data_o;
                    state_d = DMA_HALT;
                end
            end
            DMA_HALT: begin
                // Odd now means the next slot is even: a get can go straight away.
                state_d = parity_q ? DMA_GET : DMA_ALIGN;
            end
            DMA_ALIGN: begin
                state_d = DMA_GET;
            end
            DMA_GET: begin
                dma_data_d = bus.bus_data_i;
                state_d    = DMA_PUT;
            end
            DMA_PUT: begin
                cnt_d   = cnt_q + 9'd1;
                state_d = (cnt_d == NUM_BYTES) ? DMA_DONE : DMA_GET;
            end
            DMA_DONE: begin
                cnt_d = 9'd0;
                // A new start in the completion cycle is honoured immediately.
                if (start_req) begin
                    page_d  = bus.cpu_data_o;
                    state_d = DMA_HALT;
                end else begin
                    state_d = DMA_IDLE;
                end
            end
            default: begin
                state_d = DMA_IDLE;
                cnt_d   = 9'd0;
            end
        endcase

        // Outputs follow the state being entered so they are valid for the
        // whole of that cycle. Page stays fixed: only the low byte walks.
        cpu_rdy_d    = (state_d == DMA_IDLE) || (state_d == DMA_DONE);
        dma_active_d = (state_d == DMA_GET) || (state_d == DMA_PUT);
        dma_rw_d     = (state_d != DMA_PUT);
        dma_done_d   = (state_d == DMA_DONE);
        case (state_d)
            DMA_GET: dma_addr_d = {page_d, cnt_d[7:0]};
            DMA_PUT: dma_addr_d = OAM_DATA_ADDR;
            default: dma_addr_d = 16'h0000;
        endcase
    end

    // Sequencer state and registered outputs; reset aborts any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DMA_IDLE;
            page_q       <= 8'h00;
            cnt_q        <= 9'd0;
            parity_q     <= 1'b0;
            cpu_rdy_q    <= 1'b1;
            dma_active_q <= 1'b0;
            dma_addr_q   <= 16'h0000;
            dma_rw_q     <= 1'b1;
            dma_data_q   <= 8'h00;
            dma_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            cnt_q        <= cnt_d;
            parity_q     <= parity_d;
            cpu_rdy_q    <= cpu_rdy_d;
            dma_active_q <= dma_active_d;
            dma_addr_q   <= dma_addr_d;
            dma_rw_q     <= dma_rw_d;
            dma_data_q   <= dma_data_d;
            dma_done_q   <= dma_done_d;
        end
    end

    assign bus.cpu_rdy    = cpu_rdy_q;
    assign bus.dma_active = dma_active_q;
    assign bus.dma_addr   = dma_addr_q;
    assign bus.dma_rw     = dma_rw_q;
    assign bus.dma_data_o = dma_data_q;
    assign bus.dma_done   = dma_done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for the sprite DMA sequencer: a function-defined CPU memory feeds
// bus reads, and a scoreboard holds the expected get addresses and put
// bytes queued when each transfer is kicked off.
module tb_oam_dma_ctrl;

    logic clk;
    logic rst_n;
    logic tb_par;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int put_cnt = 0;

    logic [15:0] get_q[$];
    logic [7:0]  put_q[$];

    oam_dma_ctrl_if bus_if();

    oam_dma_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of CPU memory as a pure function of address.
    function automatic logic [7:0] ram_byte(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return (lo * 8'd3) ^ a[15:8] ^ 8'h5A;
    endfunction

    // Shared bus mux: DMA owns the address while active.
    always_comb bus_if.bus_data_i = ram_byte(bus_if.dma_active ? bus_if.dma_addr : bus_if.cpu_addr);

    // Expected get/put phase: toggles every clock from reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_par <= 1'b0;
        else        tb_par <= ~tb_par;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Bus monitor: every get and put is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.dma_done === 1'b1) done_cnt++;
            if (bus_if.dma_active === 1'b1) begin
                if (bus_if.dma_rw === 1'b1) begin
                    if (get_q.size() == 0)
                        check_val("get_unexpected", 32'(bus_if.dma_addr), 32'hFFFF_FFFF);
                    else
                        check_val("get_addr", 32'(bus_if.dma_addr), 32'(get_q.pop_front()));
                end else begin
                    check_val("put_addr", 32'(bus_if.dma_addr), 32'h0000_2004);
                    if (put_q.size() == 0)
                        check_val("put_unexpected", 32'(bus_if.dma_data_o), 32'hFFFF_FFFF);
                    else
                        check_val("put_data", 32'(bus_if.dma_data_o), 32'(put_q.pop_front()));
                    put_cnt++;
                end
            end
        end
    end

    task automatic cpu_idle();
        bus_if.cpu_addr   = 16'h0000;
        bus_if.cpu_rw     = 1'b1;
        bus_if.cpu_data_o = 8'h00;
    endtask

    // Wait for the requested parity slot, queue expectations, write the page.
    // Returns at the falling edge of the HALT cycle.
    task automatic start_dma(input logic [7:0] page, input logic want_odd);
        int n;
        n = 0;
        while (tb_par !== want_odd && n < 4) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 256; i++) begin
            get_q.push_back({page, 8'(i)});
            put_q.push_back(ram_byte({page, 8'(i)}));
        end
        $display("start page=%02h parity=%0d", page, tb_par);
        bus_if.cpu_addr   = 16'h4014;
        bus_if.cpu_rw     = 1'b0;
        bus_if.cpu_data_o = page;
        @(negedge clk);
        cpu_idle();
    endtask

    // Full transfer: stall length, single done pulse, scoreboard drained.
    task automatic do_xfer(input logic [7:0] page, input logic want_odd,
                           input int exp_stall, input bit poke);
        int stall;
        int done_before;
        done_before = done_cnt;
        start_dma(page, want_odd);
        check_val("halt_no_dma", 32'(bus_if.dma_active), 32'd0);
        stall = 0;
        while (bus_if.cpu_rdy === 1'b0 && stall < 2000) begin
            stall++;
            if (poke && stall == 10) begin
                bus_if.cpu_addr   = 16'h4014;
                bus_if.cpu_rw     = 1'b0;
                bus_if.cpu_data_o = 8'h77;
            end else if (poke && stall == 11) begin
                cpu_idle();
            end
            @(negedge clk);
        end
        check_val("stall_clks", 32'(stall), 32'(exp_stall));
        check_val("done_high", 32'(bus_if.dma_done), 32'd1);
        check_val("done_no_dma", 32'(bus_if.dma_active), 32'd0);
        @(negedge clk);
        check_val("done_low", 32'(bus_if.dma_done), 32'd0);
        check_val("done_pulses", 32'(done_cnt - done_before), 32'd1);
        check_val("gets_left", 32'(get_q.size()), 32'd0);
        check_val("puts_left", 32'(put_q.size()), 32'd0);
        $display("xfer page=%02h stall=%0d checks=%0d errors=%0d", page, stall, checks, errors);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_cpu_rdy"},    32'(bus_if.cpu_rdy),    32'd1);
        check_val({tag, "_dma_active"}, 32'(bus_if.dma_active), 32'd0);
        check_val({tag, "_dma_rw"},     32'(bus_if.dma_rw),     32'd1);
        check_val({tag, "_dma_addr"},   32'(bus_if.dma_addr),   32'd0);
        check_val({tag, "_dma_data"},   32'(bus_if.dma_data_o), 32'd0);
        check_val({tag, "_dma_done"},   32'(bus_if.dma_done),   32'd0);
    endtask

    initial begin
        int base;
        int n;
        rst_n = 1'b1;
        cpu_idle();

        // Asynchronous reset, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        $display("reset async checked");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Aligned, unaligned (with an ignored re-write) and top-page transfers.
        do_xfer(8'h02, 1'b0, 513, 1'b0);
        do_xfer(8'h02, 1'b1, 514, 1'b1);
        do_xfer(8'hFF, 1'b0, 513, 1'b0);

        // Reset in the middle of a transfer, then a clean restart.
        base = put_cnt;
        start_dma(8'h05, 1'b0);
        n = 0;
        while (put_cnt < base + 100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("mid_reached", 32'(put_cnt - base), 32'd100);
        rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        $display("reset mid-transfer after %0d puts", put_cnt - base);
        get_q.delete();
        put_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_xfer(8'h03, 1'b0, 513, 1'b0);

        // Read of the DMA register and write to a neighbour must not start a transfer.
        bus_if.cpu_addr = 16'h4014;
        bus_if.cpu_rw   = 1'b1;
        @(negedge clk);
        bus_if.cpu_addr   = 16'h4015;
        bus_if.cpu_rw     = 1'b0;
        bus_if.cpu_data_o = 8'h02;
        @(negedge clk);
        cpu_idle();
        for (int i = 0; i < 4; i++) begin
            check_val("nostart_rdy", 32'(bus_if.cpu_rdy), 32'd1);
            check_val("nostart_active", 32'(bus_if.dma_active), 32'd0);
            @(negedge clk);
        end
        $display("no-start accesses checked");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
